rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 16, maximum consecutive cycles one grant is held (legal range 2..256).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: req  input  4  per-requester request, level.
REQ-005 SHALL have port: done  input  4  per-requester release strobe; only the granted bit is honoured.
REQ-006 SHALL have port: gnt  output  4  one-hot grant, registered.
REQ-007 SHALL have port: gnt_valid  output  1  high while any gnt bit is high (equal to |gnt).
REQ-008 SHALL have port: gnt_id  output  2  index of the granted requester; 0 when gnt_valid is low.
REQ-009 SHALL have port: timeout  output  1  one-cycle pulse marking a forced release.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT and GAP, all outputs registered.
REQ-011 SHALL hold a 2-bit round-robin pointer ptr; arbitration picks the first i with req[i]=1, searching ptr, ptr+1, ... mod 4.
REQ-012 SHALL, in IDLE with req!=0 at an edge, enter GRANT with the picked gnt bit set; gnt is visible the cycle after req is first sampled high (latency 1).
REQ-013 SHALL remain in IDLE with gnt=0 while req==0.
REQ-014 SHALL use a hold counter sized for MAX_HOLD-1: cleared on entry to GRANT, incremented each cycle spent in GRANT.
REQ-015 SHALL leave GRANT at an edge where done[gnt_id]=1 or req[gnt_id]=0 (normal release), clearing gnt and entering GAP.
REQ-016 SHALL force release when the hold counter equals MAX_HOLD-1 without a normal release; gnt is therefore high for exactly MAX_HOLD cycles and timeout=1 during the following GAP cycle only.
REQ-017 SHALL give a normal release priority over a coincident timeout; in that case timeout stays 0.
REQ-018 SHALL ignore done and req changes on non-granted indices while in GRANT; there is no preemption.
REQ-019 SHALL, on leaving GRANT, set ptr = gnt_id+1 mod 4 (3 wraps to 0).
REQ-020 SHALL keep gnt=0 for exactly one cycle in GAP, then enter GRANT if req!=0 (arbitrated with the updated ptr), else IDLE.
REQ-021 SHALL never assert more than one gnt bit, and SHALL never assert gnt in IDLE or GAP.
REQ-022 SHALL ignore X-free but stray done pulses in IDLE and GAP.

Reset
REQ-023 SHALL, at any edge with rst=1, force state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, timeout=0, ptr=0 and hold counter=0, overriding all other inputs.
REQ-024 SHALL, when rst is asserted mid-GRANT, drop gnt the cycle after the reset edge without a GAP cycle or timeout pulse.
REQ-025 SHALL start arbitration in the first cycle after rst deasserts, using ptr=0.

Verification
REQ-026 SHALL check: rst, then req=0001 -> gnt=0001, gnt_id=0, gnt_valid=1 in the next cycle.
REQ-027 SHALL check: req=1111 held, done[gnt_id] pulsed in each grant's first cycle -> grants 0,1,2,3,0, each lasting 1 cycle and separated by one gnt=0 cycle.
REQ-028 SHALL check: MAX_HOLD=16, req=0100 held, no done -> gnt=0100 for exactly 16 cycles, timeout=1 for 1 cycle, then gnt=0100 again.
REQ-029 SHALL check: done[gnt_id]=1 on the cycle the counter equals 15 -> release with timeout=0.
REQ-030 SHALL check: rst pulsed while gnt=1000, then req=1010 -> gnt=0010 in the first grant after reset (ptr=0).
REQ-031 SHALL check: gnt=0001 with done=0010 and req[1] toggling -> gnt unchanged, no release.

Source files
------------

// File: rtl/rr_arbiter.sv
// Four-way round-robin arbiter with a bounded grant hold time.
// A grant is released when its owner strobes done or drops req. It is also released
// when the grant has been held for MAX_HOLD cycles. Every release is followed by one
// idle GAP cycle. A forced release is flagged by a one-cycle timeout pulse.
module rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic [1:0] gnt_id,
    output logic       timeout
);

    // Counter only has to reach MAX_HOLD-1, the value at which release is forced.
    localparam int unsigned CntW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [1:0]      id_q, id_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;

    logic            pick_found;
    logic [1:0]      pick_id;
    logic            normal_rel;
    logic            hold_end;

    // Round-robin pick: first requester at or after ptr, wrapping modulo 4.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!pick_found && req[ptr_q + 2'(k)]) begin
                pick_found = 1'b1;
                pick_id    = ptr_q + 2'(k);
            end
        end
    end

    // Only the current owner's done/req lines can end a grant; others are ignored.
    assign normal_rel = done[id_q] | ~req[id_q];
    assign hold_end   = (cnt_q == HoldLast);

    // State register and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
            gnt_q     <= 4'd0;
            id_q      <= 2'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state decision.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|req) state_d = StGrant;
            StGrant: if (normal_rel || hold_end) state_d = StGap;
            StGap:   state_d = (|req) ? StGrant : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs, the pointer and the hold counter.
    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle, StGap: begin
                if (|req) begin
                    gnt_d = 4'b0001 << pick_id;
                    id_d  = pick_id;
                end else begin
                    gnt_d = 4'd0;
                    id_d  = 2'd0;
                end
                cnt_d = '0;
            end
            StGrant: begin
                if (normal_rel || hold_end) begin
                    gnt_d     = 4'd0;
                    id_d      = 2'd0;
                    cnt_d     = '0;
                    ptr_d     = id_q + 2'd1;
                    // A normal release wins over a coincident hold expiry.
                    timeout_d = ~normal_rel;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                gnt_d = 4'd0;
                id_d  = 2'd0;
                cnt_d = '0;
            end
        endcase
        valid_d = |gnt_d;
    end

    assign gnt       = gnt_q;
    assign gnt_valid = valid_q;
    assign gnt_id    = id_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter with the default MAX_HOLD of 16.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;

    int passed = 0;
    int total  = 0;

    rr_arbiter #(
        .MAX_HOLD(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_valid(gnt_valid),
        .gnt_id   (gnt_id),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] id_of(input logic [3:0] g);
        case (g)
            4'b0010: id_of = 2'd1;
            4'b0100: id_of = 2'd2;
            4'b1000: id_of = 2'd3;
            default: id_of = 2'd0;
        endcase
    endfunction

    task automatic chk_out(input string tag, input logic [3:0] exp_gnt, input logic exp_to);
        chk({tag, ".gnt"}, {4'd0, gnt}, {4'd0, exp_gnt});
        chk({tag, ".valid"}, {7'd0, gnt_valid}, {7'd0, |exp_gnt});
        chk({tag, ".id"}, {6'd0, gnt_id}, {6'd0, id_of(exp_gnt)});
        chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, exp_to});
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'd0;
        done = 4'd0;
        tick();
        tick();
        chk_out("reset", 4'b0000, 1'b0);
        rst = 1'b0;

        // Single requester, latency of one cycle.
        req = 4'b0001;
        tick();
        chk_out("first_grant", 4'b0001, 1'b0);
        done = 4'b0001;
        tick();
        done = 4'b0000;
        req  = 4'b0000;
        chk_out("first_gap", 4'b0000, 1'b0);
        tick();
        chk_out("idle0", 4'b0000, 1'b0);
        done = 4'b1111;
        tick();
        chk_out("idle_stray_done", 4'b0000, 1'b0);
        done = 4'b0000;

        // Full rotation from ptr=0 with done in each grant's first cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_out($sformatf("rot%0d.grant", i), 4'b0001 << (i % 4), 1'b0);
            done = 4'b0001 << (i % 4);
            tick();
            done = 4'b1111;
            chk_out($sformatf("rot%0d.gap", i), 4'b0000, 1'b0);
            if (i < 4) tick();
        end
        done = 4'b0000;
        req  = 4'b0000;
        tick();
        chk_out("rot_idle", 4'b0000, 1'b0);

        // Forced release after exactly 16 grant cycles (ptr is 1 here).
        req = 4'b0100;
        tick();
        for (int c = 0; c < 16; c++) begin
            chk_out($sformatf("hold%0d", c), 4'b0100, 1'b0);
            tick();
        end
        chk_out("hold_timeout", 4'b0000, 1'b1);
        tick();
        chk_out("regrant", 4'b0100, 1'b0);

        // done on the cycle the counter is 15: normal release, no timeout.
        for (int c = 0; c < 15; c++) tick();
        chk_out("cnt15", 4'b0100, 1'b0);
        done = 4'b0100;
        tick();
        done = 4'b0000;
        chk_out("late_done_gap", 4'b0000, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("idle1", 4'b0000, 1'b0);

        // Reset mid-grant, then arbitration restarts from ptr=0 (ptr is 3 here).
        req = 4'b1010;
        tick();
        chk_out("pre_rst_grant", 4'b1000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("mid_grant_rst", 4'b0000, 1'b0);
        tick();
        chk_out("post_rst_grant", 4'b0010, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("req_drop_gap", 4'b0000, 1'b0);
        tick();

        // Activity on a non-granted index does not disturb the grant (ptr is 2 here).
        req = 4'b0001;
        tick();
        chk_out("np_grant", 4'b0001, 1'b0);
        done = 4'b0010;
        for (int t = 0; t < 6; t++) begin
            req = (t % 2 == 1) ? 4'b0011 : 4'b0001;
            tick();
            chk_out($sformatf("np%0d", t), 4'b0001, 1'b0);
        end
        done = 4'b0001;
        tick();
        done = 4'b0000;
        req  = 4'b0000;
        chk_out("np_release", 4'b0000, 1'b0);
        tick();
        chk_out("final_idle", 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
